// File: rtl/brg_cgra_csr_pkg.sv
// Shared definitions for the CGRA CSR endpoint slave: register word
// indices and controller states.
package brg_cgra_csr_pkg;

  localparam logic [4:0] CSR_CTRL     = 5'd0;
  localparam logic [4:0] CSR_STATUS   = 5'd1;
  localparam logic [4:0] CSR_RESULT   = 5'd2;
  localparam logic [4:0] CSR_CYCLES   = 5'd3;
  localparam logic [4:0] CSR_CFG_BASE = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } csr_state_e;

endpackage

// File: rtl/brg_cgra_csr_slave.sv
// CSR endpoint slave for a CGRA: holds configuration words, launches the
// array with a one-cycle go pulse, captures its result and reports status.
// Optional busy-cycle counter enabled by macro BRG_CGRA_CSR_CYCLE_COUNTER_EN.
module brg_cgra_csr_slave
  import brg_cgra_csr_pkg::*;
#(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned num_cfg_p    = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              in_v_i,
  input  logic                              in_we_i,
  input  logic [addr_width_p-1:0]           in_addr_i,
  input  logic [data_width_p-1:0]           in_data_i,
  input  logic [data_width_p/8-1:0]         in_mask_i,
  output logic                              in_yumi_o,
  output logic                              returning_v_o,
  output logic [data_width_p-1:0]           returning_data_o,
  output logic [num_cfg_p*data_width_p-1:0] cfg_o,
  output logic                              go_o,
  input  logic                              done_i,
  input  logic [data_width_p-1:0]           result_i
);

  localparam int unsigned mask_w_lp = data_width_p / 8;

  csr_state_e                                state_r;
  logic                                      err_r;
  logic                                      go_r;
  logic                                      resp_v_r;
  logic [data_width_p-1:0]                   resp_data_r;
  logic [data_width_p-1:0]                   result_r;
  logic [data_width_p-1:0]                   cycles;
  logic [num_cfg_p-1:0][data_width_p-1:0]    cfg_r;
  logic [data_width_p-1:0]                   rdata;

  logic [4:0] idx;
  logic       wr, rd, is_busy, cfg_hit, go_req, start, cfg_wr, err_set;
  logic       unused_addr;

  assign idx         = in_addr_i[4:0];
  assign unused_addr = ^in_addr_i[addr_width_p-1:5];
  assign wr          = in_v_i & in_we_i;
  assign rd          = in_v_i & ~in_we_i;
  assign is_busy     = (state_r == ST_BUSY);
  assign cfg_hit     = idx[4] & (32'(idx[3:0]) < num_cfg_p);
  assign go_req      = wr & (idx == CSR_CTRL) & in_data_i[0];
  assign start       = go_req & ~is_busy;
  assign cfg_wr      = wr & cfg_hit & ~is_busy;
  assign err_set     = is_busy & (go_req | (wr & cfg_hit));

  assign in_yumi_o        = in_v_i;
  assign returning_v_o    = resp_v_r;
  assign returning_data_o = resp_data_r;
  assign go_o             = go_r;
  assign cfg_o            = cfg_r;

  // Controller: go wins over nothing in BUSY, so a same-cycle done/go completes
  // to DONE and the go only raises err.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (start) state_r <= ST_BUSY;
        ST_BUSY: if (done_i) state_r <= ST_DONE;
        ST_DONE: begin
          if (start)                           state_r <= ST_BUSY;
          else if (rd && (idx == CSR_STATUS))  state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Go pulse, sticky error flag and captured result.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      go_r     <= 1'b0;
      err_r    <= 1'b0;
      result_r <= '0;
    end else begin
      go_r <= start;
      if (start)        err_r <= 1'b0;
      else if (err_set) err_r <= 1'b1;
      if (is_busy && done_i) result_r <= result_i;
    end
  end

`ifdef BRG_CGRA_CSR_CYCLE_COUNTER_EN
  logic [data_width_p-1:0] cycles_r;

  // Saturating count of BUSY cycles, restarted by each accepted go.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cycles_r <= '0;
    end else if (start) begin
      cycles_r <= '0;
    end else if (is_busy && (cycles_r != '1)) begin
      cycles_r <= cycles_r + {{(data_width_p-1){1'b0}}, 1'b1};
    end
  end

  assign cycles = cycles_r;
`else
  assign cycles = '0;
`endif

  // Byte-masked configuration writes, blocked while the array runs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cfg_r <= '0;
    end else if (cfg_wr) begin
      for (int unsigned n = 0; n < num_cfg_p; n++) begin
        if (idx[3:0] == 4'(n)) begin
          for (int unsigned b = 0; b < mask_w_lp; b++) begin
            if (in_mask_i[b]) cfg_r[n][8*b +: 8] <= in_data_i[8*b +: 8];
          end
        end
      end
    end
  end

  // Read data decode; CTRL and unmapped indices read zero.
  always_comb begin
    rdata = '0;
    case (idx)
      CSR_STATUS: rdata[2:0] = {err_r, (state_r == ST_DONE), is_busy};
      CSR_RESULT: rdata = result_r;
      CSR_CYCLES: rdata = cycles;
      default: begin
        if (cfg_hit) begin
          for (int unsigned n = 0; n < num_cfg_p; n++) begin
            if (idx[3:0] == 4'(n)) rdata = cfg_r[n];
          end
        end
      end
    endcase
  end

  // Registered response, one cycle after every accepted request.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      resp_v_r    <= 1'b0;
      resp_data_r <= '0;
    end else begin
      resp_v_r    <= in_v_i;
      resp_data_r <= rd ? rdata : '0;
    end
  end

endmodule
